// File: rtl/id_stage.sv
// RV32I decode stage: operand collection, immediate/control decode, load-use stall, ID/EX register.
// Optional WB_BYPASS_EN forwards the same-edge writeback data; without it a matching write stalls one cycle.
module id_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            flush,
  output logic [4:0]      rf_ra1,
  output logic [4:0]      rf_ra2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  output logic            ex_is_store,
  output logic            ex_is_branch,
  output logic            ex_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_write;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            illegal;
  } ex_t;

  ex_t ex_q, ex_d;

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic            legal, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j, fmt_r;
  logic            use_rs1, use_rs2;
  logic [XLEN-1:0] imm, rs1_val, rs2_val;
  logic            hold, luse, wb_stall;

  always_comb begin
    opcode = if_instr[6:0];
    rs1    = if_instr[19:15];
    rs2    = if_instr[24:20];
    rd     = if_instr[11:7];
    legal  = 1'b1;
    fmt_i  = 1'b0;
    fmt_s  = 1'b0;
    fmt_b  = 1'b0;
    fmt_u  = 1'b0;
    fmt_j  = 1'b0;
    fmt_r  = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC:                              fmt_u = 1'b1;
      OP_JAL:                                        fmt_j = 1'b1;
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: fmt_i = 1'b1;
      OP_BRANCH:                                     fmt_b = 1'b1;
      OP_STORE:                                      fmt_s = 1'b1;
      OP_REG:                                        fmt_r = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    imm = '0;
    if (fmt_i)      imm = {{20{if_instr[31]}}, if_instr[31:20]};
    else if (fmt_s) imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    else if (fmt_b) imm = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    else if (fmt_u) imm = {if_instr[31:12], 12'b0};
    else if (fmt_j) imm = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    use_rs1 = fmt_i | fmt_s | fmt_b | fmt_r;
    use_rs2 = fmt_s | fmt_b | fmt_r;
  end

  assign rf_ra1 = rs1;
  assign rf_ra2 = rs2;

  // x0 is forced to zero after any forwarding so neither rf nor wb can leak into it
  always_comb begin
    rs1_val  = rf_rd1;
    rs2_val  = rf_rd2;
    wb_stall = 1'b0;
`ifdef WB_BYPASS_EN
    if (wb_we && (wb_wa != 5'd0) && (wb_wa == rs1)) rs1_val = wb_wd;
    if (wb_we && (wb_wa != 5'd0) && (wb_wa == rs2)) rs2_val = wb_wd;
`else
    wb_stall = if_valid & wb_we & (wb_wa != 5'd0) &
               ((use_rs1 & (wb_wa == rs1)) | (use_rs2 & (wb_wa == rs2)));
`endif
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

`ifndef WB_BYPASS_EN
  logic unused_wb_wd;
  assign unused_wb_wd = ^wb_wd;
`endif

  assign hold = ex_q.valid & ~ex_ready;
  assign luse = if_valid & ex_q.valid & ex_q.is_load & (ex_q.rd != 5'd0) &
                ((use_rs1 & (ex_q.rd == rs1)) | (use_rs2 & (ex_q.rd == rs2)));
  assign id_ready = ~rst & ~hold & ~luse & ~wb_stall & ~flush;

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d.valid = 1'b0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (if_valid && !luse && !wb_stall) begin
      ex_d.valid     = 1'b1;
      ex_d.pc        = if_pc;
      ex_d.rs1_val   = rs1_val;
      ex_d.rs2_val   = rs2_val;
      ex_d.imm       = imm;
      ex_d.rd        = rd;
      ex_d.opcode    = opcode;
      ex_d.funct3    = if_instr[14:12];
      ex_d.funct7b5  = if_instr[30];
      ex_d.reg_write = legal & ~fmt_s & ~fmt_b & (opcode != OP_FENCE) & (rd != 5'd0);
      ex_d.is_load   = (opcode == OP_LOAD);
      ex_d.is_store  = (opcode == OP_STORE);
      ex_d.is_branch = (opcode == OP_BRANCH);
      ex_d.illegal   = ~legal;
    end else begin
      ex_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      ex_q.pc <= RESET_PC;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_imm       = ex_q.imm;
  assign ex_rd        = ex_q.rd;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7b5  = ex_q.funct7b5;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_is_load   = ex_q.is_load;
  assign ex_is_store  = ex_q.is_store;
  assign ex_is_branch = ex_q.is_branch;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: decode vector table through a scoreboard, plus reset, load-use,
// backpressure/flush and writeback-snoop sequences. Honours WB_BYPASS_EN like the design.
module tb_id_stage;

  localparam logic [31:0] RESET_PC_T = 32'h0000_0080;

  logic        clk, rst, if_valid, id_ready, flush, wb_we, ex_valid, ex_ready;
  logic [31:0] if_instr, if_pc, rf_rd1, rf_rd2, wb_wd;
  logic [4:0]  rf_ra1, rf_ra2, wb_wa, ex_rd;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_write, ex_is_load, ex_is_store, ex_is_branch, ex_illegal;

  id_stage #(.XLEN(32), .RESET_PC(RESET_PC_T)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_is_branch(ex_is_branch),
    .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reg_file model: x0 returns junk on purpose, the stage must still produce 0
  logic [31:0] rf_m [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        rf_m[i] <= (i == 0) ? 32'hBAD0_0000 : (32'h1000_0000 | (i * 32'h101));
    end else if (wb_we && wb_wa != 5'd0) begin
      rf_m[wb_wa] <= wb_wd;
    end
  end
  assign rf_rd1 = rf_m[rf_ra1];
  assign rf_rd2 = rf_m[rf_ra2];

  // ctrl = {reg_write, is_load, is_store, is_branch, illegal}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  ctrl;
    logic [4:0]  rd;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        use1;
    logic        use2;
  } exp_t;

  exp_t sb[$];
  vec_t cur;
  vec_t tbl[12];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic vec_t mk(logic [31:0] instr, logic [31:0] pc, logic [31:0] imm,
                              logic [4:0] ctrl, logic [4:0] rd);
    vec_t v;
    v.instr = instr; v.pc = pc; v.imm = imm; v.ctrl = ctrl; v.rd = rd;
    return v;
  endfunction

  // architectural register value as seen by an instruction issued this cycle
  function automatic logic [31:0] latest(logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_we && wb_wa == r) return wb_wd;
    return rf_m[r];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    exp_t e;
    logic [6:0] op;
    if (ex_valid === 1'b1 && ex_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_transfer", ex_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", ex_pc, e.v.pc);
        chk("sb_imm", ex_imm, e.v.imm);
        chk("sb_rd", {27'b0, ex_rd}, {27'b0, e.v.rd});
        chk("sb_ctrl", {27'b0, ex_reg_write, ex_is_load, ex_is_store, ex_is_branch, ex_illegal},
            {27'b0, e.v.ctrl});
        chk("sb_fields", {21'b0, ex_opcode, ex_funct3, ex_funct7b5},
            {21'b0, e.v.instr[6:0], e.v.instr[14:12], e.v.instr[30]});
        if (e.use1) chk("sb_rs1", ex_rs1_val, e.rs1);
        if (e.use2) chk("sb_rs2", ex_rs2_val, e.rs2);
      end
    end
    if (!rst && if_valid && id_ready === 1'b1) begin
      op     = cur.instr[6:0];
      e.v    = cur;
      e.rs1  = latest(cur.instr[19:15]);
      e.rs2  = latest(cur.instr[24:20]);
      e.use2 = (op == 7'b0100011) || (op == 7'b1100011) || (op == 7'b0110011);
      e.use1 = e.use2 || (op == 7'b1100111) || (op == 7'b0000011) || (op == 7'b0010011);
      sb.push_back(e);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    sample();
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input vec_t v);
    if_valid = 1'b1; if_instr = v.instr; if_pc = v.pc; cur = v;
  endtask

  task automatic idle();
    if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
  endtask

  task automatic issue(input vec_t v);
    logic acc;
    int   n;
    n = 0;
    drive(v);
    do begin
      at_neg();
      acc = id_ready;
      at_pos();
      n++;
    end while (acc !== 1'b1 && n < 20);
    if (acc !== 1'b1) chk("issue_timeout", v.pc, 32'hFFFF_FFFF);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t addi, lw4, add54, lw0, add540, bp_a, bp_b, fl_a, fl_b, snoop, wz;
    int c0;

    tbl[0]  = mk(32'hFE21AE23, 32'h1000, 32'hFFFF_FFFC, 5'b00100, 5'd28); // sw x2,-4(x3)
    tbl[1]  = mk(32'hFE000CE3, 32'h1004, 32'hFFFF_FFF8, 5'b00010, 5'd25); // beq x0,x0,-8
    tbl[2]  = mk(32'hABCDE2B7, 32'h1008, 32'hABCD_E000, 5'b10000, 5'd5);  // lui x5,0xABCDE
    tbl[3]  = mk(32'h001000EF, 32'h100C, 32'h0000_0800, 5'b10000, 5'd1);  // jal x1,+2048
    tbl[4]  = mk(32'hFFDFF06F, 32'h1010, 32'hFFFF_FFFC, 5'b00000, 5'd0);  // jal x0,-4
    tbl[5]  = mk(32'h00000000, 32'h1014, 32'h0000_0000, 5'b00001, 5'd0);  // opcode 0000000
    tbl[6]  = mk(32'h0000008B, 32'h1018, 32'h0000_0000, 5'b00001, 5'd1);  // custom-0, rd=x1
    tbl[7]  = mk(32'h010280E7, 32'h101C, 32'h0000_0010, 5'b10000, 5'd1);  // jalr x1,16(x5)
    tbl[8]  = mk(32'hFFF18193, 32'h1020, 32'hFFFF_FFFF, 5'b10000, 5'd3);  // addi x3,x3,-1
    tbl[9]  = mk(32'h80000517, 32'h1024, 32'h8000_0000, 5'b10000, 5'd10); // auipc x10,0x80000
    tbl[10] = mk(32'h00012203, 32'h1028, 32'h0000_0000, 5'b11000, 5'd4);  // lw x4,0(x2)
    tbl[11] = mk(32'h40208333, 32'h102C, 32'h0000_0000, 5'b10000, 5'd6);  // sub x6,x1,x2

    addi   = mk(32'h00500093, 32'h0100, 32'h0000_0005, 5'b10000, 5'd1);
    lw4    = mk(32'h00012203, 32'h0200, 32'h0000_0000, 5'b11000, 5'd4);
    add54  = mk(32'h001202B3, 32'h0204, 32'h0000_0000, 5'b10000, 5'd5);
    lw0    = mk(32'h00012003, 32'h0208, 32'h0000_0000, 5'b01000, 5'd0);
    add540 = mk(32'h000202B3, 32'h020C, 32'h0000_0000, 5'b10000, 5'd5);
    bp_a   = mk(32'hFFF18193, 32'h0300, 32'hFFFF_FFFF, 5'b10000, 5'd3);
    bp_b   = mk(32'h40208333, 32'h0304, 32'h0000_0000, 5'b10000, 5'd6);
    fl_a   = mk(32'h010280E7, 32'h0400, 32'h0000_0010, 5'b10000, 5'd1);
    fl_b   = mk(32'hABCDE2B7, 32'h0404, 32'hABCD_E000, 5'b10000, 5'd5);
    snoop  = mk(32'h00738433, 32'h0500, 32'h0000_0000, 5'b10000, 5'd8);  // add x8,x7,x7
    wz     = mk(32'h000004B3, 32'h0504, 32'h0000_0000, 5'b10000, 5'd9);  // add x9,x0,x0

    // reset held two cycles with an offer pending
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1; wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'h0;
    drive(addi);
    at_pos();
    at_neg();
    chk("rst_id_ready", {31'b0, id_ready}, 32'd0);
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_ex_pc", ex_pc, RESET_PC_T);
    chk("rst_ex_imm", ex_imm, 32'h0);
    chk("rst_ex_ctrl", {27'b0, ex_reg_write, ex_is_load, ex_is_store, ex_is_branch, ex_illegal}, 32'h0);
    at_pos();
    at_neg();
    chk("rst2_id_ready", {31'b0, id_ready}, 32'd0);
    chk("rst2_ex_valid", {31'b0, ex_valid}, 32'd0);
    at_pos();
    rst = 1'b0;
    at_neg();
    chk("post_rst_ready", {31'b0, id_ready}, 32'd1);
    at_pos();
    idle();
    at_neg();
    chk("addi_valid", {31'b0, ex_valid}, 32'd1);
    chk("addi_imm", ex_imm, 32'd5);
    chk("addi_rd", {27'b0, ex_rd}, 32'd1);
    chk("addi_rw", {31'b0, ex_reg_write}, 32'd1);
    chk("addi_rs1", ex_rs1_val, 32'h0);
    at_pos();

    // decode table, back-to-back
    c0 = cyc;
    for (int i = 0; i < 12; i++) issue(tbl[i]);
    chk("throughput_cycles", cyc - c0, 32'd12);
    for (int i = 0; i < 3; i++) begin at_neg(); at_pos(); end

    // load-use: exactly one bubble
    drive(lw4);
    at_neg();
    chk("lu_lw_ready", {31'b0, id_ready}, 32'd1);
    at_pos();
    drive(add54);
    at_neg();
    chk("lu_stall_ready", {31'b0, id_ready}, 32'd0);
    chk("lu_load_in_ex", {31'b0, ex_is_load}, 32'd1);
    at_pos();
    at_neg();
    chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
    chk("lu_issue_ready", {31'b0, id_ready}, 32'd1);
    at_pos();
    idle();
    at_neg();
    chk("lu_dep_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu_dep_pc", ex_pc, 32'h0204);
    at_pos();

    // load to x0 never stalls
    drive(lw0);
    at_neg();
    at_pos();
    drive(add540);
    at_neg();
    chk("lu_x0_ready", {31'b0, id_ready}, 32'd1);
    at_pos();
    idle();
    at_neg();
    chk("lu_x0_valid", {31'b0, ex_valid}, 32'd1);
    at_pos();
    at_neg(); at_pos();

    // backpressure: payload stable for 3 cycles
    ex_ready = 1'b0;
    drive(bp_a);
    at_neg();
    chk("bp_accept", {31'b0, id_ready}, 32'd1);
    at_pos();
    drive(bp_b);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("bp_ready", {31'b0, id_ready}, 32'd0);
      chk("bp_valid", {31'b0, ex_valid}, 32'd1);
      chk("bp_imm", ex_imm, 32'hFFFF_FFFF);
      chk("bp_pc", ex_pc, 32'h0300);
      at_pos();
    end
    ex_ready = 1'b1;
    at_neg();
    chk("bp_release_ready", {31'b0, id_ready}, 32'd1);
    at_pos();
    idle();
    at_neg();
    chk("bp_next_pc", ex_pc, 32'h0304);
    at_pos();
    at_neg(); at_pos();

    // flush while holding: held instruction never transfers
    ex_ready = 1'b0;
    drive(fl_a);
    at_neg();
    at_pos();
    drive(fl_b);
    at_neg();
    chk("fl_hold_ready", {31'b0, id_ready}, 32'd0);
    at_pos();
    flush = 1'b1;
    at_neg();
    chk("fl_ready", {31'b0, id_ready}, 32'd0);
    at_pos();
    flush = 1'b0;
    idle();
    at_neg();
    chk("fl_valid", {31'b0, ex_valid}, 32'd0);
    chk("fl_sb_pending", sb.size(), 32'd1);
    if (sb.size() > 0) void'(sb.pop_front());
    at_pos();
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("fl_no_transfer", {31'b0, ex_valid}, 32'd0);
      at_pos();
    end

    // writeback snoop on x7 with stale reg_file contents
    wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'hDEAD_BEEF;
    drive(snoop);
`ifdef WB_BYPASS_EN
    at_neg();
    chk("wb_ready", {31'b0, id_ready}, 32'd1);
    at_pos();
    wb_we = 1'b0;
    idle();
`else
    at_neg();
    chk("wb_ready", {31'b0, id_ready}, 32'd0);
    at_pos();
    wb_we = 1'b0;
    at_neg();
    chk("wb_retry_ready", {31'b0, id_ready}, 32'd1);
    chk("wb_bubble", {31'b0, ex_valid}, 32'd0);
    at_pos();
    idle();
`endif
    at_neg();
    chk("wb_valid", {31'b0, ex_valid}, 32'd1);
    chk("wb_rs1", ex_rs1_val, 32'hDEAD_BEEF);
    chk("wb_rs2", ex_rs2_val, 32'hDEAD_BEEF);
    at_pos();

    // write to x0 is neither forwarded nor stalls
    wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'h1234_5678;
    drive(wz);
    at_neg();
    chk("wz_ready", {31'b0, id_ready}, 32'd1);
    at_pos();
    wb_we = 1'b0;
    idle();
    at_neg();
    chk("wz_valid", {31'b0, ex_valid}, 32'd1);
    chk("wz_rs1", ex_rs1_val, 32'h0);
    chk("wz_rs2", ex_rs2_val, 32'h0);
    at_pos();

    for (int k = 0; k < 3; k++) begin at_neg(); at_pos(); end
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I instruction-decode stage directly upstream of EX and directly downstream of reg_file's read ports.
- Accepts a fetched instruction and PC from IF, drives reg_file read addresses, collects operands, and generates the immediate and control bits.
- Detects load-use hazards and captures everything into an ID/EX pipeline register with valid/ready handshakes on both sides.
- The write-port snoop from writeback covers the same-edge write-then-read window of reg_file.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- RESET_PC, 32'h0000_0000, value driven on ex_pc while held in reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- if_valid  in  1  IF offers if_instr/if_pc.
- if_instr  in  32  instruction word.
- if_pc  in  32  instruction address.
- id_ready  out  1  ID accepts the IF offer this cycle.
- flush  in  1  kill the instruction in ID and the ID/EX register (branch redirect).
- rf_ra1  out  5  reg_file ra1 = if_instr[19:15]; combinational.
- rf_ra2  out  5  reg_file ra2 = if_instr[24:20]; combinational.
- rf_rd1  in  32  reg_file rd1.
- rf_rd2  in  32  reg_file rd2.
- wb_we  in  1  writeback write enable (same signal driving reg_file we).
- wb_wa  in  5  writeback address.
- wb_wd  in  32  writeback data.
- ex_valid  out  1  ID/EX register holds a valid instruction.
- ex_ready  in  1  EX accepts the ID/EX contents.
- ex_pc  out  32  registered PC.
- ex_rs1_val  out  32  registered operand 1.
- ex_rs2_val  out  32  registered operand 2.
- ex_imm  out  32  sign-extended immediate.
- ex_rd  out  5  destination register.
- ex_opcode  out  7  opcode field.
- ex_funct3  out  3  funct3 field.
- ex_funct7b5  out  1  instr[30].
- ex_reg_write  out  1  writes rd; forced 0 when rd==0.
- ex_is_load  out  1  opcode 0000011.
- ex_is_store  out  1  opcode 0100011.
- ex_is_branch  out  1  opcode 1100011.
- ex_illegal  out  1  opcode not in the RV32I base set.

Behaviour:
- Reset (rst=1 at posedge): ex_valid=0; ex_pc=RESET_PC; all other ex_* outputs 0. id_ready is 0 throughout the cycle where rst=1.
- Immediates:
  - I: instr[31:20] sign-extended.
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U: {instr[31:12],12'b0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - Any other format: 0. All immediates sign-extended to 32 bits.
- Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011. Anything else sets ex_illegal=1 and ex_reg_write=0.
- Operand read: rs index 0 always yields 0, regardless of rf or bypass.
- hold = ex_valid & ~ex_ready.
- Load-use stall: luse = ex_valid & ex_is_load & ex_rd!=0 & (ex_rd==rs1 | ex_rd==rs2 for that source's used format). rs2 is used only by S, B and R formats.
- id_ready = ~rst & ~hold & ~luse & ~flush.
- Each posedge, priority order:
  1. rst: clear.
  2. flush: ex_valid<=0; the IF offer is dropped.
  3. hold: ID/EX unchanged.
  4. if_valid & ~luse: capture the decode, ex_valid<=1.
  5. Otherwise (including luse): bubble, ex_valid<=0.
- Load-use latency: exactly one bubble cycle. The dependent instruction issues on the next cycle, provided EX accepted the load.
- Handshake transfers occur on ex_valid & ex_ready. Payload stays stable while hold.
- Back-to-back: one instruction per cycle when ex_ready=1 and there is no hazard.
- Reset mid-hold: reset wins; the held instruction is discarded.

Optional Feature:
- WB_BYPASS_EN defined: if wb_we & wb_wa!=0 & wb_wa==rs, the operand takes wb_wd instead of rf_rdN, evaluated the same cycle.
- Undefined: no bypass. The same match instead sets an extra stall term in id_ready and the bubble condition for one cycle, so the value is read from reg_file after the write edge.
- In both modes, EX-visible results are identical; only timing differs.

Test Plan:
- Reset: hold rst=1 for 2 cycles with if_valid=1 -> ex_valid=0, ex_pc=RESET_PC, id_ready=0. Release -> addi x1,x0,5 (0x00500093) at pc 0x100 yields ex_imm=5, ex_rd=1, ex_reg_write=1, ex_rs1_val=0 after 1 cycle.
- Immediates:
  - sw x2,-4(x3) (0xFE21AE23) -> ex_imm=0xFFFFFFFC, ex_is_store=1, ex_reg_write=0.
  - beq x0,x0,-8 (0xFE000CE3) -> ex_imm=0xFFFFFFF8.
  - lui x5,0xABCDE (0xABCDE2B7) -> ex_imm=0xABCDE000.
  - jal -> J-type immediate checked.
- Load-use: lw x4,0(x2) followed by add x5,x4,x1 with ex_ready=1 -> one cycle of ex_valid=0 between them, id_ready=0 during that cycle. add x5,x4,x0 right after lw x0 -> no stall.
- Backpressure/flush: ex_ready=0 for 3 cycles -> ex_* stable, id_ready=0. Flush during hold -> ex_valid=0 the next cycle and the held instruction never transfers.
- WB snoop: wb_we=1, wb_wa=7, wb_wd=0xDEADBEEF with add x8,x7,x7 and rf_rd1/rf_rd2 carrying a stale value:
  - With the macro defined -> both operands 0xDEADBEEF, no stall.
  - Without it -> one stall cycle, then operands come from rf.
  - wb_wa=0 -> no bypass, operand 0.
- Illegal: opcode 0000000 -> ex_illegal=1, ex_reg_write=0, ex_valid=1.
